// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the frame-buffer SRAM controller.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } sram_state_t;

  // Active-low SRAM control pins, kept together so they are registered as one bundle
  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic ub;
    logic lb;
  } sram_ctrl_t;

  localparam sram_ctrl_t CTRL_IDLE = '{ce: 1'b1, oe: 1'b1, we: 1'b1, ub: 1'b1, lb: 1'b1};
  localparam sram_ctrl_t CTRL_RD   = '{ce: 1'b0, oe: 1'b0, we: 1'b1, ub: 1'b0, lb: 1'b0};

  function automatic sram_ctrl_t ctrl_wr(input logic [1:0] be);
    return '{ce: 1'b0, oe: 1'b1, we: 1'b0, ub: ~be[1], lb: ~be[0]};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Client-side handshake bundle: VGA read port plus draw-engine write port.
interface sram_controller_if #(
  parameter int ADDR_W = sram_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DEF_DATA_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, rd_valid, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, rd_valid, wr_gnt
  );

endinterface

// File: rtl/sram_controller_arbiter.sv
// Read-priority arbiter; with SRAM_CTRL_FAIR_ARB_EN a pending write is forced
// through once the read-burst count reaches MAX_RD_BURST.
module sram_arbiter
`ifdef SRAM_CTRL_FAIR_ARB_EN
#(
  parameter int MAX_RD_BURST = 8,
  parameter int BURST_W      = 4
)
`endif
(
`ifdef SRAM_CTRL_FAIR_ARB_EN
  input  logic [BURST_W-1:0] burst_cnt,
`endif
  input  logic               rd_req,
  input  logic               wr_req,
  input  logic               arb_pt,
  output logic               rd_gnt,
  output logic               wr_gnt
);

  logic force_wr;

`ifdef SRAM_CTRL_FAIR_ARB_EN
  assign force_wr = wr_req && (burst_cnt >= BURST_W'(MAX_RD_BURST));
`else
  assign force_wr = 1'b0;
`endif

  assign rd_gnt = arb_pt && rd_req && !force_wr;
  assign wr_gnt = arb_pt && wr_req && (!rd_req || force_wr);

endmodule

// File: rtl/sram_controller.sv
// Arbiter and timing engine for the 1M x 16 asynchronous frame-buffer SRAM.
// Optional fair arbitration: define SRAM_CTRL_FAIR_ARB_EN.
//
// state | meaning
// IDLE  | no access in flight; SRAM deselected, DQ released
// RD    | read access; cnt counts ACCESS_CYCLES..1, DQ sampled when cnt == 1
// WR    | write access; WE low while cnt > 1, high in the final cycle for hold
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_RD_BURST  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_controller_if.slave  bus,
  output logic              SRAM_CE,
  output logic              SRAM_OE,
  output logic              SRAM_WE,
  output logic              SRAM_UB,
  output logic              SRAM_LB,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);

  if (ACCESS_CYCLES < 2) begin : g_bad_access_cycles
    $error("sram_controller: ACCESS_CYCLES must be 2 or more");
  end
  if (MAX_RD_BURST < 1) begin : g_bad_max_rd_burst
    $error("sram_controller: MAX_RD_BURST must be 1 or more");
  end

  sram_state_t       state;
  logic [CNT_W-1:0]  cnt;
  sram_ctrl_t        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic last_cyc;
  logic arb_pt;
  logic rd_gnt;
  logic wr_gnt;

  assign last_cyc = (cnt == CNT_W'(1));
  assign arb_pt   = (state == IDLE) || last_cyc;

`ifdef SRAM_CTRL_FAIR_ARB_EN
  localparam int BURST_W = $clog2(MAX_RD_BURST + 1);
  logic [BURST_W-1:0] burst_cnt;

  // Counts reads that overtook a waiting write; any gap in wr_req forgives them
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      burst_cnt <= '0;
    end else if (!bus.wr_req || wr_gnt) begin
      burst_cnt <= '0;
    end else if (rd_gnt) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  sram_arbiter #(
    .MAX_RD_BURST (MAX_RD_BURST),
    .BURST_W      (BURST_W)
  ) u_arbiter (
    .burst_cnt (burst_cnt),
    .rd_req    (bus.rd_req),
    .wr_req    (bus.wr_req),
    .arb_pt    (arb_pt),
    .rd_gnt    (rd_gnt),
    .wr_gnt    (wr_gnt)
  );
`else
  sram_arbiter u_arbiter (
    .rd_req (bus.rd_req),
    .wr_req (bus.wr_req),
    .arb_pt (arb_pt),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_q     <= CTRL_IDLE;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state == RD) && last_cyc;
      if ((state == RD) && last_cyc) begin
        rd_data_q <= SRAM_DQ;
      end

      if (arb_pt) begin
        // Releasing DQ and dropping OE on the same edge gives write-to-read turnaround
        if (rd_gnt) begin
          state   <= RD;
          cnt     <= CNT_LOAD;
          addr_q  <= bus.rd_addr;
          ctrl_q  <= CTRL_RD;
          dq_oe_q <= 1'b0;
        end else if (wr_gnt) begin
          state    <= WR;
          cnt      <= CNT_LOAD;
          addr_q   <= bus.wr_addr;
          dq_out_q <= bus.wr_data;
          dq_oe_q  <= 1'b1;
          ctrl_q   <= ctrl_wr(bus.wr_be);
        end else begin
          state   <= IDLE;
          cnt     <= '0;
          ctrl_q  <= CTRL_IDLE;
          dq_oe_q <= 1'b0;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if ((state == WR) && (cnt == CNT_W'(2))) begin
          ctrl_q.we <= 1'b1;
        end
      end
    end
  end

  assign SRAM_CE   = ctrl_q.ce;
  assign SRAM_OE   = ctrl_q.oe;
  assign SRAM_WE   = ctrl_q.we;
  assign SRAM_UB   = ctrl_q.ub;
  assign SRAM_LB   = ctrl_q.lb;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};

  assign bus.rd_gnt   = rd_gnt;
  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural async SRAM model.
module tb_sram_controller;

  logic        Clk;
  logic        Reset;
  logic        SRAM_CE, SRAM_OE, SRAM_WE, SRAM_UB, SRAM_LB;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic [4:0]  ctrl_pins;
  logic [15:0] mem [0:1023];
  logic        mdl_drive;

  int n_checks;
  int n_errs;

  sram_controller_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_controller dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .SRAM_CE   (SRAM_CE),
    .SRAM_OE   (SRAM_OE),
    .SRAM_WE   (SRAM_WE),
    .SRAM_UB   (SRAM_UB),
    .SRAM_LB   (SRAM_LB),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (sram_dq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign ctrl_pins = {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_UB, SRAM_LB};
  assign mdl_drive = !SRAM_CE && !SRAM_OE && SRAM_WE;
  assign sram_dq   = mdl_drive ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

  // SRAM model: preload, then latch byte writes at each edge while WE is low
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h345] = 16'hBEEF;
    mem[10'h010] = 16'h1234;
    forever begin
      @(posedge Clk);
      if (!SRAM_CE && !SRAM_WE) begin
        if (!SRAM_LB) mem[SRAM_ADDR[9:0]][7:0]  = sram_dq[7:0];
        if (!SRAM_UB) mem[SRAM_ADDR[9:0]][15:8] = sram_dq[15:8];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int rd_cnt, wr_cnt, first_wr, odd_gnt, both_gnt, vld_cnt;

  initial begin
    n_checks = 0;
    n_errs   = 0;
    Reset        = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = 2'b00;

    tick(); tick();
    #1;
    check("reset_ctrl", 32'(ctrl_pins), 32'h1f);
    check("reset_addr", 32'(SRAM_ADDR), 32'h0);
    check("reset_rd_data", 32'(bus.rd_data), 32'h0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    tick();
    Reset = 1'b0;
    tick();

    // Single read of 0x12345 (model holds 0xBEEF there)
    tick(); bus.rd_req = 1'b1; bus.rd_addr = 20'h12345; #1;
    check("rd_gnt", 32'(bus.rd_gnt), 32'h1);
    check("rd_no_wr_gnt", 32'(bus.wr_gnt), 32'h0);
    tick(); bus.rd_req = 1'b0; #1;
    check("rd_ctrl_t1", 32'(ctrl_pins), 32'h04);
    check("rd_addr_t1", 32'(SRAM_ADDR), 32'h12345);
    tick(); #1;
    check("rd_ctrl_t2", 32'(ctrl_pins), 32'h04);
    check("rd_valid_early", 32'(bus.rd_valid), 32'h0);
    tick(); #1;
    check("rd_valid_t3", 32'(bus.rd_valid), 32'h1);
    check("rd_data_t3", 32'(bus.rd_data), 32'hBEEF);
    check("rd_idle_t3", 32'(ctrl_pins), 32'h1f);
    tick(); #1;
    check("rd_valid_pulse", 32'(bus.rd_valid), 32'h0);
    check("rd_data_hold", 32'(bus.rd_data), 32'hBEEF);

    // Lower-byte write of 0xA55A to 0x00010 (old 0x1234)
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 20'h00010; bus.wr_data = 16'hA55A; bus.wr_be = 2'b01; #1;
    check("wr_gnt", 32'(bus.wr_gnt), 32'h1);
    tick(); bus.wr_req = 1'b0; bus.wr_data = 16'h0000; #1;
    check("bw_ctrl_t1", 32'(ctrl_pins), 32'h0a);
    check("bw_dq_t1", 32'(sram_dq), 32'hA55A);
    tick(); #1;
    check("bw_ctrl_t2", 32'(ctrl_pins), 32'h0e);
    tick(); #1;
    check("bw_idle", 32'(ctrl_pins), 32'h1f);
    check("bw_mem", 32'(mem[10'h010]), 32'h125A);

    // Write with no byte enables: still a full access, memory untouched
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 20'h00010; bus.wr_data = 16'hFFFF; bus.wr_be = 2'b00; #1;
    check("be0_gnt", 32'(bus.wr_gnt), 32'h1);
    tick(); bus.wr_req = 1'b0; #1;
    check("be0_ctrl_t1", 32'(ctrl_pins), 32'h0b);
    tick(); #1;
    check("be0_ctrl_t2", 32'(ctrl_pins), 32'h0f);
    tick(); #1;
    check("be0_mem", 32'(mem[10'h010]), 32'h125A);

    // Read back 0x00010
    tick(); bus.rd_req = 1'b1; bus.rd_addr = 20'h00010; #1;
    check("rb_gnt", 32'(bus.rd_gnt), 32'h1);
    tick(); bus.rd_req = 1'b0;
    tick(); tick(); #1;
    check("rb_valid", 32'(bus.rd_valid), 32'h1);
    check("rb_data", 32'(bus.rd_data), 32'h125A);

    // Write then read back-to-back at 0x00020
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 20'h00020; bus.wr_data = 16'hC3D4; bus.wr_be = 2'b11; #1;
    check("wtr_wr_gnt", 32'(bus.wr_gnt), 32'h1);
    tick(); bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 20'h00020; #1;
    check("wtr_ctrl_w1", 32'(ctrl_pins), 32'h08);
    check("wtr_no_gnt_mid", 32'(bus.rd_gnt), 32'h0);
    tick(); #1;
    check("wtr_ctrl_w2", 32'(ctrl_pins), 32'h0c);
    check("wtr_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    tick(); bus.rd_req = 1'b0; #1;
    check("wtr_ctrl_r1", 32'(ctrl_pins), 32'h04);
    check("wtr_dq_r1", 32'(sram_dq), 32'hC3D4);
    tick(); #1;
    check("wtr_ctrl_r2", 32'(ctrl_pins), 32'h04);
    tick(); #1;
    check("wtr_valid", 32'(bus.rd_valid), 32'h1);
    check("wtr_data", 32'(bus.rd_data), 32'hC3D4);

    // Continuous contention for 36 cycles starting from IDLE
    rd_cnt = 0; wr_cnt = 0; first_wr = -1; odd_gnt = 0; both_gnt = 0;
    tick();
    for (int i = 0; i < 36; i++) begin
      if (i == 0) begin
        bus.rd_req  = 1'b1; bus.rd_addr = 20'h12345;
        bus.wr_req  = 1'b1; bus.wr_addr = 20'h00030; bus.wr_data = 16'h5555; bus.wr_be = 2'b11;
      end
      #1;
      if (bus.rd_gnt) rd_cnt++;
      if (bus.wr_gnt) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = i;
      end
      if ((i % 2 == 1) && (bus.rd_gnt || bus.wr_gnt)) odd_gnt++;
      if (bus.rd_gnt && bus.wr_gnt) both_gnt++;
      tick();
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
`ifdef SRAM_CTRL_FAIR_ARB_EN
    check("cont_rd_grants", 32'(rd_cnt), 32'd16);
    check("cont_wr_grants", 32'(wr_cnt), 32'd2);
    check("cont_first_wr", 32'(first_wr), 32'd16);
`else
    check("cont_rd_grants", 32'(rd_cnt), 32'd18);
    check("cont_wr_grants", 32'(wr_cnt), 32'd0);
    check("cont_first_wr", 32'(first_wr), 32'hFFFF_FFFF);
`endif
    check("cont_odd_slot_gnt", 32'(odd_gnt), 32'd0);
    check("cont_dual_gnt", 32'(both_gnt), 32'd0);
    tick(); tick(); tick(); #1;
    check("cont_idle", 32'(ctrl_pins), 32'h1f);

    // Reset in the middle of a read: no rd_valid afterwards, rd_data cleared
    tick(); bus.rd_req = 1'b1; bus.rd_addr = 20'h12345; #1;
    check("rst_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    tick(); bus.rd_req = 1'b0; Reset = 1'b1; #1;
    check("rst_rd_ctrl", 32'(ctrl_pins), 32'h1f);
    check("rst_rd_data", 32'(bus.rd_data), 32'h0);
    tick(); Reset = 1'b0;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.rd_valid) vld_cnt++;
      tick();
    end
    check("rst_rd_no_valid", 32'(vld_cnt), 32'd0);

    // Reset in the middle of a write: controls return high in the same cycle
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 20'h00040; bus.wr_data = 16'h7777; bus.wr_be = 2'b11; #1;
    check("rst_wr_gnt", 32'(bus.wr_gnt), 32'h1);
    tick(); bus.wr_req = 1'b0; #1;
    check("rst_wr_active", 32'(ctrl_pins), 32'h08);
    Reset = 1'b1; #1;
    check("rst_wr_ctrl", 32'(ctrl_pins), 32'h1f);
    check("rst_wr_addr", 32'(SRAM_ADDR), 32'h0);
    tick(); Reset = 1'b0;
    vld_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.rd_valid) vld_cnt++;
      tick();
    end
    check("rst_wr_no_valid", 32'(vld_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
